// File: rtl/ysyx_23060072_ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_ex_mem_stage_if
//
// Purpose : bundles every signal that crosses the EX/MEM stage boundary.
//           This covers the EX-side valid/ready beat, the MEM-side
//           valid/ready beat, the controller flush and the redirect pulse.
//           The _i/_o suffixes are named from the stage's point of view.
//
// Modports:
//   slave  - the EX/MEM stage itself (consumes EX beats, produces MEM beats)
//   master - the surrounding pipeline (EX unit, MEM unit, controller)
//
// Signals:
//   ex_valid_i/ex_ready_o     EX beat handshake
//   ex_pc_i, alu_result_i     instruction PC and ALU result / link value
//   jump_flag_i, jump_pc_i    ALU redirect request and target
//   rd_addr_i, rd_wen_i       destination register and write enable
//   mem_ren_i, mem_wen_i      load / store request
//   mem_wdata_i               store data
//   flush_i                   synchronous controller flush
//   mem_valid_o/mem_ready_i   MEM beat handshake
//   mem_*_o                   head-entry payload
//   redirect_valid_o/_pc_o    one-cycle redirect pulse and held target
// ---------------------------------------------------------------------------
interface ysyx_23060072_ex_mem_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 4
);
    // EX side
    logic            ex_valid_i;
    logic            ex_ready_o;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] alu_result_i;
    logic            jump_flag_i;
    logic [XLEN-1:0] jump_pc_i;
    logic [RA_W-1:0] rd_addr_i;
    logic            rd_wen_i;
    logic            mem_ren_i;
    logic            mem_wen_i;
    logic [XLEN-1:0] mem_wdata_i;

    // Controller
    logic            flush_i;

    // MEM side
    logic            mem_valid_o;
    logic            mem_ready_i;
    logic [XLEN-1:0] mem_pc_o;
    logic [XLEN-1:0] mem_result_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [RA_W-1:0] mem_rd_addr_o;
    logic            mem_rd_wen_o;
    logic            mem_ren_o;
    logic            mem_wen_o;

    // Redirect to controller / IF
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport slave (
        input  ex_valid_i,
        output ex_ready_o,
        input  ex_pc_i,
        input  alu_result_i,
        input  jump_flag_i,
        input  jump_pc_i,
        input  rd_addr_i,
        input  rd_wen_i,
        input  mem_ren_i,
        input  mem_wen_i,
        input  mem_wdata_i,
        input  flush_i,
        output mem_valid_o,
        input  mem_ready_i,
        output mem_pc_o,
        output mem_result_o,
        output mem_wdata_o,
        output mem_rd_addr_o,
        output mem_rd_wen_o,
        output mem_ren_o,
        output mem_wen_o,
        output redirect_valid_o,
        output redirect_pc_o
    );

    modport master (
        output ex_valid_i,
        input  ex_ready_o,
        output ex_pc_i,
        output alu_result_i,
        output jump_flag_i,
        output jump_pc_i,
        output rd_addr_i,
        output rd_wen_i,
        output mem_ren_i,
        output mem_wen_i,
        output mem_wdata_i,
        output flush_i,
        input  mem_valid_o,
        output mem_ready_i,
        input  mem_pc_o,
        input  mem_result_o,
        input  mem_wdata_o,
        input  mem_rd_addr_o,
        input  mem_rd_wen_o,
        input  mem_ren_o,
        input  mem_wen_o,
        input  redirect_valid_o,
        input  redirect_pc_o
    );
endinterface

// File: rtl/ysyx_23060072_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_ex_mem_stage
//
// Purpose : EX->MEM pipeline register implemented as a 2-entry in-order
//           buffer (EMPTY / ONE / FULL). The head entry drives the MEM
//           outputs directly. The second entry absorbs one beat of MEM
//           back-pressure, so ex_ready_o never depends on mem_ready_i.
//           A pushed beat that requests a jump raises a one-cycle redirect
//           pulse. While that pulse is up, any EX beat is wrong-path: it is
//           handshaken and dropped. A flush empties the buffer and cancels
//           any pending redirect.
//
// Ports   :
//   clk_i    - clock, rising edge
//   rst_n_i  - asynchronous active-low reset
//   bus      - ysyx_23060072_ex_mem_stage_if.slave (EX beat, MEM beat,
//              flush, redirect)
//
// All outputs come from flops except ex_ready_o, which is a function of
// registered state only.
// ---------------------------------------------------------------------------
module ysyx_23060072_ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    ysyx_23060072_ex_mem_stage_if.slave         bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] wdata;
        logic [RA_W-1:0] rd_addr;
        logic            rd_wen;
        logic            ren;
        logic            wen;
    } beat_t;

    // Gathers the incoming EX payload into one beat (bit-exact copy).
    function automatic beat_t pack_beat(
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] result,
        input logic [XLEN-1:0] wdata,
        input logic [RA_W-1:0] rd_addr,
        input logic            rd_wen,
        input logic            ren,
        input logic            wen
    );
        beat_t b;
        b.pc      = pc;
        b.result  = result;
        b.wdata   = wdata;
        b.rd_addr = rd_addr;
        b.rd_wen  = rd_wen;
        b.ren     = ren;
        b.wen     = wen;
        return b;
    endfunction

    state_e          state_q,       state_d;
    beat_t           head_q,        head_d;
    beat_t           tail_q,        tail_d;
    logic            mem_valid_q,   mem_valid_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q,    redir_pc_d;

    logic            ex_ready_s;
    logic            push_s;
    logic            pop_s;
    beat_t           in_beat_s;

    // Handshake decode. A redirect pulse forces ready so wrong-path beats drain.
    always_comb begin
        ex_ready_s = (state_q != ST_FULL) | redir_valid_q;
        push_s     = bus.ex_valid_i & ex_ready_s & ~redir_valid_q & ~bus.flush_i;
        pop_s      = mem_valid_q & bus.mem_ready_i;
        in_beat_s  = pack_beat(bus.ex_pc_i, bus.alu_result_i, bus.mem_wdata_i,
                               bus.rd_addr_i, bus.rd_wen_i, bus.mem_ren_i,
                               bus.mem_wen_i);
    end

    // Next-state, buffer-entry and redirect computation.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;

        if (bus.flush_i) begin
            // A flush wins over push, pop and any pending redirect. Payload
            // and redirect target are left as they are.
            state_d       = ST_EMPTY;
            redir_valid_d = 1'b0;
        end else begin
            // The redirect pulse lasts exactly one cycle after the jumping push.
            if (push_s && bus.jump_flag_i) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = bus.jump_pc_i;
            end else begin
                redir_valid_d = 1'b0;
            end

            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_d  = in_beat_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        // Head leaves this cycle, so the new beat takes its place.
                        head_d  = in_beat_s;
                        state_d = ST_ONE;
                    end else if (push_s) begin
                        tail_d  = in_beat_s;
                        state_d = ST_FULL;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // No push can happen here: ready in FULL only comes from
                    // a redirect pulse, and that pulse blocks the push.
                    if (pop_s) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        mem_valid_d = (state_d != ST_EMPTY);
    end

    // State, buffer entries and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_EMPTY;
            head_q        <= '0;
            tail_q        <= '0;
            mem_valid_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            mem_valid_q   <= mem_valid_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign bus.ex_ready_o       = ex_ready_s;
    assign bus.mem_valid_o      = mem_valid_q;
    assign bus.mem_pc_o         = head_q.pc;
    assign bus.mem_result_o     = head_q.result;
    assign bus.mem_wdata_o      = head_q.wdata;
    assign bus.mem_rd_addr_o    = head_q.rd_addr;
    assign bus.mem_rd_wen_o     = head_q.rd_wen;
    assign bus.mem_ren_o        = head_q.ren;
    assign bus.mem_wen_o        = head_q.wen;
    assign bus.redirect_valid_o = redir_valid_q;
    assign bus.redirect_pc_o    = redir_pc_q;

endmodule

// File: tb/tb_ysyx_23060072_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060072_ex_mem_stage
//
// Scoreboard bench for the EX/MEM 2-entry buffer. The bench keeps its own
// expected queue of accepted beats and its own redirect state. Each cycle it
// first checks ex_ready_o against that state. It then decides from the same
// state whether the beat is accepted. After the edge it checks the MEM head
// and the redirect outputs.
// ---------------------------------------------------------------------------
module tb_ysyx_23060072_ex_mem_stage;
    localparam int XLEN = 32;
    localparam int RA_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic        rd_wen;
        logic        ren;
        logic        wen;
    } exp_beat_t;

    logic clk;
    logic rst_n;

    ysyx_23060072_ex_mem_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    ysyx_23060072_ex_mem_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    exp_beat_t   sb_q[$];
    logic        model_redir;
    logic [31:0] model_rpc;
    logic        last_push;
    int          n_vec;
    int          n_err;
    int          n_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_beat(input logic [31:0] pc, input logic [31:0] result,
                              input logic [31:0] wdata, input logic [3:0] rd,
                              input logic rd_wen, input logic ren, input logic wen,
                              input logic jump, input logic [31:0] jpc);
        bus.ex_valid_i   = 1'b1;
        bus.ex_pc_i      = pc;
        bus.alu_result_i = result;
        bus.mem_wdata_i  = wdata;
        bus.rd_addr_i    = rd;
        bus.rd_wen_i     = rd_wen;
        bus.mem_ren_i    = ren;
        bus.mem_wen_i    = wen;
        bus.jump_flag_i  = jump;
        bus.jump_pc_i    = jpc;
    endtask

    task automatic idle_ex();
        bus.ex_valid_i  = 1'b0;
        bus.jump_flag_i = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("mem_valid", 32'(bus.mem_valid_o), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check_eq("mem_pc",      bus.mem_pc_o,              sb_q[0].pc);
            check_eq("mem_result",  bus.mem_result_o,          sb_q[0].result);
            check_eq("mem_wdata",   bus.mem_wdata_o,           sb_q[0].wdata);
            check_eq("mem_rd_addr", 32'(bus.mem_rd_addr_o),    32'(sb_q[0].rd));
            check_eq("mem_ctl",     32'({bus.mem_rd_wen_o, bus.mem_ren_o, bus.mem_wen_o}),
                                    32'({sb_q[0].rd_wen, sb_q[0].ren, sb_q[0].wen}));
        end
        check_eq("redirect_valid", 32'(bus.redirect_valid_o), 32'(model_redir));
        check_eq("redirect_pc",    bus.redirect_pc_o,         model_rpc);
    endtask

    // One clock: check ready, predict push/pop, clock, update model, check outputs.
    task automatic cycle();
        logic      exp_ready;
        logic      push;
        logic      pop;
        exp_beat_t b;
        exp_ready = (sb_q.size() != 2) || model_redir;
        check_eq("ex_ready", 32'(bus.ex_ready_o), 32'(exp_ready));
        push = bus.ex_valid_i && exp_ready && !model_redir && !bus.flush_i;
        pop  = (sb_q.size() != 0) && bus.mem_ready_i;
        b.pc     = bus.ex_pc_i;
        b.result = bus.alu_result_i;
        b.wdata  = bus.mem_wdata_i;
        b.rd     = bus.rd_addr_i;
        b.rd_wen = bus.rd_wen_i;
        b.ren    = bus.mem_ren_i;
        b.wen    = bus.mem_wen_i;
        @(posedge clk);
        #1;
        if (bus.flush_i) begin
            sb_q.delete();
            model_redir = 1'b0;
            last_push   = 1'b0;
        end else begin
            if (pop) begin
                void'(sb_q.pop_front());
                n_pop++;
            end
            if (push) sb_q.push_back(b);
            model_redir = push && bus.jump_flag_i;
            if (model_redir) model_rpc = bus.jump_pc_i;
            last_push = push;
        end
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_mem_valid"}, 32'(bus.mem_valid_o),      32'h0);
        check_eq({tag, "_redir_v"},   32'(bus.redirect_valid_o), 32'h0);
        check_eq({tag, "_redir_pc"},  bus.redirect_pc_o,         32'h0);
        check_eq({tag, "_mem_pc"},    bus.mem_pc_o,              32'h0);
        check_eq({tag, "_mem_res"},   bus.mem_result_o,          32'h0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata_o,           32'h0);
        check_eq({tag, "_mem_ctl"},   32'({bus.mem_rd_addr_o, bus.mem_rd_wen_o,
                                           bus.mem_ren_o, bus.mem_wen_o}), 32'h0);
        check_eq({tag, "_ex_ready"},  32'(bus.ex_ready_o),       32'h1);
    endtask

    initial begin
        int pop_base;
        n_vec = 0; n_err = 0; n_pop = 0;
        model_redir = 1'b0; model_rpc = 32'h0; last_push = 1'b0;
        rst_n = 1'b0;
        bus.flush_i     = 1'b0;
        bus.mem_ready_i = 1'b1;
        drive_beat(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle_ex();

        #12;
        check_reset_state("rst");

        // Reset release, then the first push lands on the very first edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive_beat(32'h8000_0000, 32'h5, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check_eq("first_push_pc", bus.mem_pc_o, 32'h8000_0000);
        idle_ex();
        cycle();

        // Back-pressure: A, B fill the buffer, C is stalled, then all drain in order.
        pop_base = n_pop;
        bus.mem_ready_i = 1'b0;
        drive_beat(32'h100, 32'hA, 32'h11, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        drive_beat(32'h104, 32'hB, 32'h22, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle();
        drive_beat(32'h108, 32'hC, 32'h33, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check_eq("full_ex_ready", 32'(bus.ex_ready_o), 32'h0);
        bus.mem_ready_i = 1'b1;
        begin
            int budget;
            budget = 8;
            last_push = 1'b0;
            while (!last_push && budget > 0) begin
                cycle();
                budget--;
            end
            if (!last_push) check_eq("c_accept_timeout", 32'h0, 32'h1);
        end
        idle_ex();
        repeat (3) cycle();
        check_eq("abc_pop_count", 32'(n_pop - pop_base), 32'd3);

        // JAL redirect, wrong-path beat dropped, link value forwarded.
        drive_beat(32'h200, 32'h204, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
        cycle();
        check_eq("jal_redir_v", 32'(bus.redirect_valid_o), 32'h1);
        check_eq("jal_redir_pc", bus.redirect_pc_o, 32'h400);
        drive_beat(32'h204, 32'hDEAD, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check_eq("jal_pulse_end", 32'(bus.redirect_valid_o), 32'h0);
        idle_ex();
        repeat (2) cycle();

        // FULL plus pending redirect, then a flush with simultaneous beat and ready.
        bus.mem_ready_i = 1'b0;
        drive_beat(32'h500, 32'h1, 32'h2, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        drive_beat(32'h504, 32'h508, 32'h3, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600);
        cycle();
        drive_beat(32'h600, 32'h9, 32'h4, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.flush_i     = 1'b1;
        bus.mem_ready_i = 1'b1;
        cycle();
        check_eq("flush_mem_valid", 32'(bus.mem_valid_o), 32'h0);
        check_eq("flush_redir_v",   32'(bus.redirect_valid_o), 32'h0);
        check_eq("flush_ex_ready",  32'(bus.ex_ready_o), 32'h1);
        bus.flush_i = 1'b0;
        idle_ex();
        cycle();

        // ONE with simultaneous push and pop: new beat replaces the head.
        bus.mem_ready_i = 1'b0;
        drive_beat(32'h2F0, 32'h7, 32'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        bus.mem_ready_i = 1'b1;
        drive_beat(32'h300, 32'h8, 32'h0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check_eq("swap_pc", bus.mem_pc_o, 32'h300);
        check_eq("swap_valid", 32'(bus.mem_valid_o), 32'h1);
        idle_ex();
        cycle();

        // Random traffic with occasional jumps and flushes.
        for (int i = 0; i < 400; i++) begin
            bus.mem_ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 2) != 0) begin
                drive_beat($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), $urandom);
            end else begin
                idle_ex();
            end
            cycle();
        end
        bus.flush_i = 1'b0;

        // Asynchronous reset mid-stream, checked before the next edge.
        bus.mem_ready_i = 1'b0;
        drive_beat(32'h700, 32'h1, 32'h2, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h900);
        cycle();
        drive_beat(32'h704, 32'h5, 32'h6, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        sb_q.delete();
        model_redir = 1'b0;
        model_rpc   = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready_i = 1'b1;
        drive_beat(32'h800, 32'h42, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        check_eq("post_rst_push_pc", bus.mem_pc_o, 32'h800);
        idle_ex();
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060072_ex_mem_stage.md
YSYX_23060072_EX_MEM_STAGE -- requirements
Module: ysyx_23060072_ex_mem_stage

Interface
REQ-001 Parameters SHALL be: XLEN, 32, datapath width; RA_W, 4, register-address width (RV32E, 16 GPRs).
REQ-002 Clock: clk_i  in  1  single clock, all state updates on rising edge.
REQ-003 Reset: rst_n_i  in  1  asynchronous, active-low.
REQ-004 ex_valid_i  in  1  EX beat valid.
REQ-005 ex_ready_o  out  1  stage can accept an EX beat.
REQ-006 ex_pc_i  in  XLEN  instruction PC.
REQ-007 alu_result_i  in  XLEN  ALU operand result (JAL/JALR link value included).
REQ-008 jump_flag_i  in  1  ALU redirect request (taken branch, JAL, JALR, FENCE_I).
REQ-009 jump_pc_i  in  XLEN  ALU redirect target.
REQ-010 rd_addr_i / rd_wen_i  in  RA_W / 1  destination register and write enable.
REQ-011 mem_ren_i / mem_wen_i  in  1 / 1  load / store request.
REQ-012 mem_wdata_i  in  XLEN  store data.
REQ-013 flush_i  in  1  controller flush (trap/exception), synchronous.
REQ-014 mem_valid_o  out  1  MEM beat valid; mem_ready_i  in  1  MEM accepts.
REQ-015 mem_pc_o, mem_result_o, mem_wdata_o  out  XLEN; mem_rd_addr_o  out  RA_W; mem_rd_wen_o, mem_ren_o, mem_wen_o  out  1  head-entry payload.
REQ-016 redirect_valid_o  out  1  one-cycle redirect pulse to controller/IF; redirect_pc_o  out  XLEN  target.

Function
REQ-017 Block SHALL be a 2-entry in-order buffer, states EMPTY, ONE, FULL (entry count 0/1/2); all outputs registered except ex_ready_o.
REQ-018 push = ex_valid_i & ex_ready_o & !redirect_valid_o & !flush_i; pop = mem_valid_o & mem_ready_i.
REQ-019 ex_ready_o SHALL = (state != FULL) | redirect_valid_o.
REQ-020 Transitions: EMPTY -push-> ONE; ONE -push&!pop-> FULL; ONE -pop&!push-> EMPTY; ONE -push&pop-> ONE (head replaced by new beat); FULL -pop-> ONE (second entry becomes head); otherwise hold.
REQ-021 Latency: beat pushed in cycle N SHALL appear on mem_*_o with mem_valid_o=1 in N+1 when state was EMPTY, or when state was ONE and the head popped in N.
REQ-022 mem_*_o payload SHALL hold stable while mem_valid_o=1 and mem_ready_i=0.
REQ-023 On push with jump_flag_i=1: redirect_valid_o=1 and redirect_pc_o=jump_pc_i in cycle N+1 only (single-cycle pulse); the jumping instruction itself SHALL still be buffered and forwarded.
REQ-024 Wrong-path drop: any beat presented while redirect_valid_o=1 SHALL be handshaken (ex_ready_o=1) and discarded, with no state or redirect change.
REQ-025 flush_i=1 SHALL force state EMPTY, mem_valid_o=0, redirect_valid_o=0 on next edge, overriding simultaneous push, pop, and pending redirect.
REQ-026 redirect_pc_o SHALL hold its last value when redirect_valid_o=0.
REQ-027 Payload SHALL be carried bit-exact, no arithmetic or width change.

Reset
REQ-028 While rst_n_i=0 (asynchronous, mid-operation included): state EMPTY, mem_valid_o=0, redirect_valid_o=0, all payload and redirect_pc_o = 0, ex_ready_o=1.
REQ-029 First push SHALL be accepted in the first rising edge with rst_n_i=1.

Verification
REQ-030 Reset then push pc=0x80000000, result=0x5, rd=3, wen=1, mem_ready_i=1 -> next cycle mem_valid_o=1, mem_pc_o=0x80000000, mem_result_o=0x5, mem_rd_addr_o=3.
REQ-031 mem_ready_i=0, push A(pc=0x100), B(pc=0x104), present C -> ex_ready_o=0 after B, C held; raise mem_ready_i -> A, B, C emerge in order, no loss/duplication.
REQ-032 Push JAL pc=0x200, jump_pc=0x400, result=0x204 -> next cycle redirect_valid_o=1, redirect_pc_o=0x400 for exactly one cycle; beat pc=0x204 presented that cycle dropped; mem_result_o=0x204 forwarded.
REQ-033 State FULL with pending redirect, assert flush_i -> next cycle mem_valid_o=0, redirect_valid_o=0, ex_ready_o=1.
REQ-034 rst_n_i low mid-stream between edges -> outputs clear immediately, before next clock edge.
REQ-035 State ONE, simultaneous push(pc=0x300) and pop -> state ONE, mem_pc_o=0x300 next cycle.
